// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline write-back
// stage and the long-latency (mul/div) result path. Pipeline writes always
// win; long results wait in a 2-entry FIFO and drain into idle slots. An age
// counter forces a one-cycle pipeline stall so a buffered result cannot starve.
// A 32-bit busy scoreboard marks destinations with outstanding long operations.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteAddressW,
  input  logic [31:0] RegInDataW,
  input  logic        IssueValid,
  input  logic [4:0]  IssueAddress,
  input  logic        LongValid,
  input  logic [4:0]  LongAddress,
  input  logic [31:0] LongData,
  output logic        LongReady,
  output logic        RegWriteD,
  output logic [4:0]  WriteAddressD,
  output logic [31:0] RegInDataD,
  output logic        StallReq,
  output logic [31:0] BusyVec
);

  localparam logic [3:0] AgeLimit = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } fifoEntry_t;

  fifoEntry_t  fifoMem [2];
  logic        rdPtr;
  logic        wrPtr;
  logic [1:0]  count;
  logic [3:0]  age;
  logic [31:0] busyVec;
  logic [31:0] busyNext;

  logic        fifoEmpty;
  logic        slotUsed;
  logic        pop;
  logic        push;
  logic        longReadyInt;
  logic        stallInt;
  fifoEntry_t  head;

  assign fifoEmpty = (count == 2'd0);
  assign head      = fifoMem[rdPtr];

  // Handshake, stall and slot decisions; ready/stall come from registered state only.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    longReadyInt = 1'b0;
    stallInt     = 1'b0;
    slotUsed     = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    if (!RESET) begin
      longReadyInt = (count != 2'd2);
      stallInt     = (age == AgeLimit);
      slotUsed     = RegWriteW && (WriteAddressW != 5'd0) && !stallInt;
      pop          = !slotUsed && !fifoEmpty;
      // Results to x0 complete the handshake but are dropped here.
      push         = longReadyInt && LongValid && (LongAddress != 5'd0);
    end
  end

  // Port mux: pipeline slot first, FIFO head into idle slots, otherwise all zero.
  always_comb begin
    RegWriteD     = 1'b0;
    WriteAddressD = 5'd0;
    RegInDataD    = 32'd0;
    if (slotUsed) begin
      RegWriteD     = 1'b1;
      WriteAddressD = WriteAddressW;
      RegInDataD    = RegInDataW;
    end else if (pop) begin
      RegWriteD     = 1'b1;
      WriteAddressD = head.addr;
      RegInDataD    = head.data;
    end
  end

  // Scoreboard next value: drain clears, issue sets, and set wins on a collision.
  always_comb begin
    busyNext = busyVec;
    if (pop) begin
      busyNext[head.addr] = 1'b0;
    end
    if (IssueValid && (IssueAddress != 5'd0)) begin
      busyNext[IssueAddress] = 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge CLK) begin
    // NOTE: storage arrays are left unreset on purpose; the pointers and count
    // define validity, and leaving data unreset keeps it plain RAM/flops.
    if (push) begin
      fifoMem[wrPtr] <= '{addr: LongAddress, data: LongData};
    end
  end

  // Pointers, occupancy, age counter and scoreboard with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      count   <= 2'd0;
      age     <= 4'd0;
      busyVec <= 32'd0;
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + 2'(push) - 2'(pop);
      if (fifoEmpty || pop) begin
        age <= 4'd0;
      end else if (age != AgeLimit) begin
        age <= age + 4'd1;
      end
      busyVec <= busyNext;
    end
  end

  assign LongReady = longReadyInt;
  assign StallReq  = stallInt;
  assign BusyVec   = busyVec;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        CLK;
  logic        RESET;
  logic        RegWriteW;
  logic [4:0]  WriteAddressW;
  logic [31:0] RegInDataW;
  logic        IssueValid;
  logic [4:0]  IssueAddress;
  logic        LongValid;
  logic [4:0]  LongAddress;
  logic [31:0] LongData;
  logic        LongReady;
  logic        RegWriteD;
  logic [4:0]  WriteAddressD;
  logic [31:0] RegInDataD;
  logic        StallReq;
  logic [31:0] BusyVec;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RegWriteW    (RegWriteW),
    .WriteAddressW(WriteAddressW),
    .RegInDataW   (RegInDataW),
    .IssueValid   (IssueValid),
    .IssueAddress (IssueAddress),
    .LongValid    (LongValid),
    .LongAddress  (LongAddress),
    .LongData     (LongData),
    .LongReady    (LongReady),
    .RegWriteD    (RegWriteD),
    .WriteAddressD(WriteAddressD),
    .RegInDataD   (RegInDataD),
    .StallReq     (StallReq),
    .BusyVec      (BusyVec)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mQ[$];
  int          mAge   = 0;
  logic [31:0] mBusy  = 32'd0;
  bit          mValid = 1'b0;

  // Compare at the falling edge (inputs are stable), then advance the model one clock.
  always @(negedge CLK) begin
    logic        expW;
    logic [4:0]  expA;
    logic [31:0] expD;
    logic        expStall;
    logic        expReady;
    bit          popNow;
    bit          wasEmpty;
    ent_t        e;
    expW = 1'b0; expA = 5'd0; expD = 32'd0;
    expStall = 1'b0; expReady = 1'b0; popNow = 1'b0;
    wasEmpty = (mQ.size() == 0);
    if (!RESET) begin
      expStall = (mAge == LIMIT);
      expReady = (mQ.size() < 2);
      if (RegWriteW && WriteAddressW != 5'd0 && !expStall) begin
        expW = 1'b1; expA = WriteAddressW; expD = RegInDataW;
      end else if (mQ.size() > 0) begin
        expW = 1'b1; expA = mQ[0].a; expD = mQ[0].d; popNow = 1'b1;
      end
    end
    check("m_regwrite", 32'(RegWriteD), 32'(expW));
    check("m_addr", 32'(WriteAddressD), 32'(expA));
    check("m_data", RegInDataD, expD);
    check("m_stall", 32'(StallReq), 32'(expStall));
    check("m_ready", 32'(LongReady), 32'(expReady));
    if (mValid) check("m_busy", BusyVec, mBusy);

    if (RESET) begin
      mQ.delete();
      mAge   = 0;
      mBusy  = 32'd0;
      mValid = 1'b1;
    end else begin
      if (wasEmpty || popNow) mAge = 0;
      else if (mAge < LIMIT) mAge++;
      if (popNow) begin
        e = mQ.pop_front();
        mBusy[e.a] = 1'b0;
      end
      if (IssueValid && IssueAddress != 5'd0) mBusy[IssueAddress] = 1'b1;
      if (LongValid && expReady && LongAddress != 5'd0) mQ.push_back('{LongAddress, LongData});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    RegWriteW = 1'b0; WriteAddressW = 5'd0; RegInDataW = 32'd0;
    IssueValid = 1'b0; IssueAddress = 5'd0;
    LongValid = 1'b0; LongAddress = 5'd0; LongData = 32'd0;
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    RegWriteW = 1'b1; WriteAddressW = a; RegInDataW = d;
  endtask

  task automatic offer(input logic [4:0] a, input logic [31:0] d);
    LongValid = 1'b1; LongAddress = a; LongData = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [4:0] seen[$];
  logic [4:0] offers[3];
  logic [4:0] want;
  int         oi;

  initial begin
    // Reset with active inputs: forced outputs must stay low.
    RESET = 1'b1;
    idle();
    pipe(5'd3, 32'd1);
    offer(5'd5, 32'd2);
    #2;
    check("rst_regwrite", 32'(RegWriteD), 32'd0);
    check("rst_stall", 32'(StallReq), 32'd0);
    check("rst_ready", 32'(LongReady), 32'd0);
    tick();
    tick();
    RESET = 1'b0;
    #1;
    check("post_rst_ready", 32'(LongReady), 32'd1);
    check("post_rst_busy", BusyVec, 32'd0);
    check("post_rst_regwrite", 32'(RegWriteD), 32'd0);

    // Idle drain.
    tick(); offer(5'd5, 32'hDEADBEEF); #1;
    check("drain_accept_ready", 32'(LongReady), 32'd1);
    check("drain_accept_nowrite", 32'(RegWriteD), 32'd0);
    tick(); #1;
    check("drain_regwrite", 32'(RegWriteD), 32'd1);
    check("drain_addr", 32'(WriteAddressD), 32'd5);
    check("drain_data", RegInDataD, 32'hDEADBEEF);
    check("drain_ready", 32'(LongReady), 32'd1);
    tick(); #1;
    check("drain_done", 32'(RegWriteD), 32'd0);

    // Priority and starvation.
    tick(); pipe(5'd3, 32'h333); offer(5'd7, 32'h777); #1;
    check("prio_first", 32'(WriteAddressD), 32'd3);
    for (int i = 1; i <= 4; i++) begin
      tick(); pipe(5'd3, 32'h333); #1;
      check("prio_addr", 32'(WriteAddressD), 32'd3);
      check("prio_nostall", 32'(StallReq), 32'd0);
    end
    tick(); pipe(5'd3, 32'h333); #1;
    check("starve_stall", 32'(StallReq), 32'd1);
    check("starve_addr", 32'(WriteAddressD), 32'd7);
    check("starve_data", RegInDataD, 32'h777);
    tick(); pipe(5'd3, 32'h333); #1;
    check("starve_release", 32'(StallReq), 32'd0);
    check("starve_resume", 32'(WriteAddressD), 32'd3);

    // Full FIFO under continuous pipeline writes.
    offers[0] = 5'd10; offers[1] = 5'd11; offers[2] = 5'd12;
    oi = 0;
    seen.delete();
    for (int c = 0; c < 30; c++) begin
      tick();
      pipe(5'd3, 32'h1000 + 32'(c));
      if (oi < 3) offer(offers[oi], 32'hA000 + 32'(offers[oi]));
      #1;
      if (c == 2) check("full_ready_low", 32'(LongReady), 32'd0);
      if (c == 5) begin
        check("full_stall", 32'(StallReq), 32'd1);
        check("full_drain_ready_low", 32'(LongReady), 32'd0);
      end
      if (LongValid && LongReady) oi++;
      if (RegWriteD && WriteAddressD != 5'd3) seen.push_back(WriteAddressD);
    end
    check("full_accepted", 32'(oi), 32'd3);
    check("full_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      want = (i < seen.size()) ? seen[i] : 5'd31;
      check("full_order", 32'(want), 32'(offers[i]));
    end

    // x0 handling.
    tick(); offer(5'd20, 32'h14);
    tick(); pipe(5'd0, 32'h999); offer(5'd0, 32'hBAD); #1;
    check("x0_regwrite", 32'(RegWriteD), 32'd1);
    check("x0_addr", 32'(WriteAddressD), 32'd20);
    check("x0_data", RegInDataD, 32'h14);
    check("x0_accept", 32'(LongReady), 32'd1);
    tick(); #1;
    check("x0_dropped", 32'(RegWriteD), 32'd0);
    check("x0_ready", 32'(LongReady), 32'd1);
    tick(); #1;
    check("x0_dropped2", 32'(RegWriteD), 32'd0);

    // Scoreboard.
    tick(); IssueValid = 1'b1; IssueAddress = 5'd9; #1;
    check("sb_not_yet", BusyVec, 32'd0);
    tick(); offer(5'd9, 32'h99); #1;
    check("sb_set", BusyVec, 32'h200);
    tick(); IssueValid = 1'b1; IssueAddress = 5'd9; #1;
    check("sb_drain_addr", 32'(WriteAddressD), 32'd9);
    tick(); offer(5'd9, 32'h98); #1;
    check("sb_set_wins", BusyVec, 32'h200);
    tick(); #1;
    check("sb_drain2", 32'(WriteAddressD), 32'd9);
    tick(); #1;
    check("sb_cleared", BusyVec, 32'd0);

    // Reset mid-operation: two entries buffered, x9 busy, age 3.
    tick(); pipe(5'd3, 32'h3); IssueValid = 1'b1; IssueAddress = 5'd9; offer(5'd21, 32'h21);
    tick(); pipe(5'd3, 32'h3); offer(5'd22, 32'h22);
    tick(); pipe(5'd3, 32'h3);
    tick(); pipe(5'd3, 32'h3); #1;
    check("pre_rst_busy", BusyVec, 32'h200);
    check("pre_rst_full", 32'(LongReady), 32'd0);
    tick(); pipe(5'd3, 32'h3); offer(5'd23, 32'h23); RESET = 1'b1; #1;
    check("mid_rst_regwrite", 32'(RegWriteD), 32'd0);
    check("mid_rst_stall", 32'(StallReq), 32'd0);
    check("mid_rst_ready", 32'(LongReady), 32'd0);
    tick(); RESET = 1'b0; #1;
    check("after_rst_regwrite", 32'(RegWriteD), 32'd0);
    check("after_rst_stall", 32'(StallReq), 32'd0);
    check("after_rst_ready", 32'(LongReady), 32'd1);
    check("after_rst_busy", BusyVec, 32'd0);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      int dens;
      tick();
      dens = (c / 250) % 4;
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) < dens + 1) pipe(5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) offer(5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        IssueValid = 1'b1;
        IssueAddress = 5'($urandom_range(0, 7));
      end
    end
    tick();
    RESET = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
